// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants (fetch stage and main decode controller).
// Pure declarations: no logic, no latency.
// Fetch state encodings are plain localparams so legacy controller code can compare them directly.
package mips_pkg;

  localparam int OPCODE_W = 6;
  localparam int INSTR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;
  localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IF_IDLE = 2'd0;
  localparam fetch_state_t IF_REQ  = 2'd1;
  localparam fetch_state_t IF_HOLD = 2'd2;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter: reset load, +4 advance, redirect load (load wins over advance).
// Latency: new PC visible one cycle after load/inc.
// Backpressure: none; the caller only asserts inc when a word is accepted.
module if_pc_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n)    pc <= RESET_PC;
    else if (load) pc <= load_pc;
    else if (inc)  pc <= pc + ADDR_W'(4);
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, one imem request in flight, presents instr/opcode/pc+4 to decode.
// Latency: 1 instr/cycle with zero-wait memory; id_* registered on the response edge.
// Backpressure: stall holds id_*, one word parks in a hold buffer; IF_DELAY_SLOT_EN keeps it across redirects.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                stall,
  output logic                id_valid,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [ADDR_W-1:0]   id_pc4
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic               alt_vld;   // in-flight request is for alt_addr, pc already redirected
  logic [ADDR_W-1:0]  alt_addr;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  word_pc4;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc4;
  logic               deliver;
  logic               pc_inc;

  assign cur_addr  = alt_vld ? alt_addr : pc;
  assign word_pc4  = cur_addr + ADDR_W'(4);
  assign imem_req  = (state == IF_REQ);
  assign imem_addr = cur_addr;
  assign id_opcode = opcode_of(id_instr);

`ifdef IF_DELAY_SLOT_EN
  assign deliver = (state == IF_REQ) && imem_rvalid;
`else
  // alt_vld doubles as the drop flag: the stale response is swallowed
  assign deliver = (state == IF_REQ) && imem_rvalid && !alt_vld && !redirect_valid;
`endif
  assign pc_inc  = deliver && !alt_vld;

  if_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (pc_inc),
    .load    (redirect_valid),
    .load_pc (redirect_pc & ~ADDR_W'(3)),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IF_IDLE;
      alt_vld    <= 1'b0;
      alt_addr   <= '0;
      id_valid   <= 1'b0;
      id_instr   <= NOP;
      id_pc4     <= '0;
      hold_instr <= NOP;
      hold_pc4   <= '0;
    end else begin
      if (state == IF_REQ && imem_rvalid) begin
        alt_vld <= 1'b0;
      end else if (state == IF_REQ && redirect_valid && !alt_vld) begin
        alt_vld  <= 1'b1;
        alt_addr <= pc;
      end

      case (state)
        IF_IDLE: state <= IF_REQ;
        IF_REQ: begin
          if (deliver) begin
            if (!stall || !id_valid) begin
              id_instr <= imem_rdata;
              id_pc4   <= word_pc4;
              id_valid <= 1'b1;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc4   <= word_pc4;
              state      <= IF_HOLD;
            end
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
        end
        IF_HOLD: begin
          if (!stall) begin
            id_instr <= hold_instr;
            id_pc4   <= hold_pc4;
            id_valid <= 1'b1;
            state    <= IF_REQ;
          end
        end
        default: state <= IF_IDLE;
      endcase

`ifndef IF_DELAY_SLOT_EN
      if (redirect_valid) begin
        id_valid   <= 1'b0;
        id_instr   <= NOP;
        hold_instr <= NOP;
        if (state == IF_HOLD) state <= IF_REQ;
      end
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns its own address as the instruction word.
// Inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr, id_pc4;
  logic [5:0]  id_opcode;

  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc4_2;
  logic [5:0]  opcode2;
  logic        redir2 = 1'b0;
  logic [31:0] redir_pc2 = 32'h0;
  logic        stall2 = 1'b0;

  int lat = 0;
  int wcnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rvalid = imem_req && (wcnt >= lat);
  assign imem_rdata  = imem_addr;
  assign rvalid2     = req2;
  assign rdata2      = addr2;

  always @(posedge clk) begin
    if (!imem_req || imem_rvalid) wcnt <= 0;
    else                          wcnt <= wcnt + 1;
  end

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_opcode(id_opcode), .id_pc4(id_pc4)
  );

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect_valid(redir2), .redirect_pc(redir_pc2), .stall(stall2),
    .id_valid(valid2), .id_instr(instr2), .id_opcode(opcode2), .id_pc4(pc4_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();
    check("rst_req", imem_req, 0);
    check("rst_valid", id_valid, 0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc4", id_pc4, 32'h0);

    // 1: zero-wait streaming from reset
    rst_n = 1'b1;
    step();
    check("t1_req", imem_req, 1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", id_valid, 0);
    check("t5_addr0", addr2, 32'hFFFF_FFFC);
    step();
    check("t1_valid1", id_valid, 1);
    check("t1_pc4_a", id_pc4, 32'd4);
    check("t1_instr_a", id_instr, 32'h0);
    check("t5_pc4", pc4_2, 32'h0);
    check("t5_instr", instr2, 32'hFFFF_FFFC);
    check("t5_opcode", opcode2, 6'h3F);
    check("t5_addr1", addr2, 32'h0);
    step();
    check("t1_pc4_b", id_pc4, 32'd8);
    check("t1_instr_b", id_instr, 32'd4);
    step();
    check("t1_pc4_c", id_pc4, 32'd12);
    check("t1_instr_c", id_instr, 32'd8);

    // 2: three stall cycles while word 8 is held
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_instr", id_instr, 32'd8);
      check("t2_hold_pc4", id_pc4, 32'd12);
      check("t2_no_req", imem_req, 0);
    end
    stall = 1'b0;
    step();
    check("t2_buf_instr", id_instr, 32'd12);
    check("t2_buf_pc4", id_pc4, 32'd16);
    check("t2_req_back", imem_req, 1);
    check("t2_addr", imem_addr, 32'd16);
    step();
    check("t2_next_instr", id_instr, 32'd16);
    check("t2_next_pc4", id_pc4, 32'd20);

    // 3: redirect while a slow request to 20 is outstanding
    lat = 2;
    step();
    check("t3_valid_drop", id_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check("t3_addr_stable", imem_addr, 32'd20);
    check("t3_valid_a", id_valid, 0);
    step();
`ifdef IF_DELAY_SLOT_EN
    check("t3_slot_valid", id_valid, 1);
    check("t3_slot_instr", id_instr, 32'd20);
`else
    check("t3_dropped", id_valid, 0);
`endif
    check("t3_target", imem_addr, 32'h0000_0100);
    check("t3_req", imem_req, 1);
    step();
    check("t3_wait_a", id_valid, 0);
    step();
    check("t3_wait_b", id_valid, 0);
    step();
    check("t3_valid_b", id_valid, 1);
    check("t3_instr", id_instr, 32'h0000_0100);
    check("t3_pc4", id_pc4, 32'h0000_0104);

`ifndef IF_DELAY_SLOT_EN
    // 4: redirect and stall in the same cycle with the hold buffer full
    lat = 0;
    stall = 1'b1;
    step();
    check("t4_hold_req", imem_req, 0);
    check("t4_hold_instr", id_instr, 32'h0000_0100);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check("t4_flush_valid", id_valid, 0);
    check("t4_flush_nop", id_instr, 32'h0);
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h0000_0200);
    step();
    check("t4_empty_capture", id_instr, 32'h0000_0200);
    check("t4_valid", id_valid, 1);
    stall = 1'b0;
    step();
    check("t4_no_stale", id_instr, 32'h0000_0204);
    check("t4_pc4", id_pc4, 32'h0000_0208);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
